// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe, debounces
// press and release at slot ends, and hands one decoded key per press to a valid/ack register.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV         = 100000,
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_pressed,
  output logic       overflow
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_SAMPLES);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        row_s1, row_s2;
  logic [SLOT_W-1:0] slot;
  logic [3:0]        col_nxt;
  logic [1:0]        cand_col, cand_col_nxt;
  logic [1:0]        cand_row, cand_row_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [3:0]        code_nxt;
  logic              valid_nxt, pressed_nxt, ovf_nxt;
  logic              slot_end, row_any, cand_low, accept;
  logic [1:0]        col_idx, row_pick;
  logic [3:0]        accept_code;

  function automatic logic [3:0] decode(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] k;
    case ({c, r})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h4;
      4'b00_10: k = 4'h7;
      4'b00_11: k = 4'h0;
      4'b01_00: k = 4'h2;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h8;
      4'b01_11: k = 4'hF;
      4'b10_00: k = 4'h3;
      4'b10_01: k = 4'h6;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hE;
      4'b11_00: k = 4'hA;
      4'b11_01: k = 4'hB;
      4'b11_10: k = 4'hC;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  // Slot timing and row decode helpers
  always_comb begin
    slot_end = (slot == SLOT_LAST);
    row_any  = ~&row_s2;
    cand_low = ~row_s2[cand_row];
    if (!col[0])      col_idx = 2'd0;
    else if (!col[1]) col_idx = 2'd1;
    else if (!col[2]) col_idx = 2'd2;
    else              col_idx = 2'd3;
    if (!row_s2[0])      row_pick = 2'd0;
    else if (!row_s2[1]) row_pick = 2'd1;
    else if (!row_s2[2]) row_pick = 2'd2;
    else                 row_pick = 2'd3;
  end

  // Next-state and output logic
  always_comb begin
    state_nxt    = state;
    col_nxt      = col;
    cand_col_nxt = cand_col;
    cand_row_nxt = cand_row;
    cnt_nxt      = cnt;
    code_nxt     = key_code;
    valid_nxt    = key_valid & ~key_ack;
    pressed_nxt  = key_pressed;
    ovf_nxt      = overflow;
    accept       = 1'b0;
    accept_code  = 4'h0;

    case (state)
      SCAN: begin
        if (slot_end) begin
          if (row_any) begin
            cand_col_nxt = col_idx;
            cand_row_nxt = row_pick;
            if (DEBOUNCE_SAMPLES == 1) begin
              accept      = 1'b1;
              accept_code = decode(col_idx, row_pick);
              cnt_nxt     = CNT_W'(0);
              state_nxt   = RELEASE;
            end else begin
              cnt_nxt   = CNT_W'(1);
              state_nxt = DEBOUNCE;
            end
          end else begin
            col_nxt = {col[2:0], col[3]};
          end
        end
      end
      DEBOUNCE: begin
        if (slot_end) begin
          if (cand_low) begin
            if (cnt + 1'b1 == CNT_DONE) begin
              accept      = 1'b1;
              accept_code = decode(cand_col, cand_row);
              cnt_nxt     = CNT_W'(0);
              state_nxt   = RELEASE;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end else begin
            cnt_nxt   = CNT_W'(0);
            state_nxt = SCAN;
            col_nxt   = {col[2:0], col[3]};
          end
        end
      end
      RELEASE: begin
        // Only the latched row counts; other rows are ignored until release completes
        if (slot_end) begin
          if (!cand_low) begin
            if (cnt + 1'b1 == CNT_DONE) begin
              pressed_nxt = 1'b0;
              cnt_nxt     = CNT_W'(0);
              state_nxt   = SCAN;
              col_nxt     = {col[2:0], col[3]};
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end else begin
            cnt_nxt = CNT_W'(0);
          end
        end
      end
      default: state_nxt = SCAN;
    endcase

    if (accept) begin
      pressed_nxt = 1'b1;
      if (!key_valid || key_ack) begin
        code_nxt  = accept_code;
        valid_nxt = 1'b1;
      end else begin
        ovf_nxt = 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SCAN;
      row_s1      <= 4'hF;
      row_s2      <= 4'hF;
      slot        <= SLOT_W'(0);
      col         <= 4'b1110;
      cand_col    <= 2'd0;
      cand_row    <= 2'd0;
      cnt         <= CNT_W'(0);
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      row_s1      <= row;
      row_s2      <= row_s1;
      slot        <= slot_end ? SLOT_W'(0) : slot + 1'b1;
      col         <= col_nxt;
      cand_col    <= cand_col_nxt;
      cand_row    <= cand_row_nxt;
      cnt         <= cnt_nxt;
      key_code    <= code_nxt;
      key_valid   <= valid_nxt;
      key_pressed <= pressed_nxt;
      overflow    <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix model
// (SCAN_DIV=4, DEBOUNCE_SAMPLES=3).
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_ack;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_pressed, overflow;

  logic       pressed, glitch;
  logic [1:0] pc, pr;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc;
  logic       seen;

  typedef struct {
    logic [1:0] c;
    logic [1:0] r;
    logic [3:0] code;
  } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SAMPLES(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_pressed (key_pressed),
    .overflow    (overflow)
  );

  // Keypad matrix: a held key pulls its row low only while its column is strobed
  always_comb begin
    row = 4'hF;
    if (pressed && !glitch && !col[pc]) row[pr] = 1'b0;
  end

  function automatic logic [3:0] colmask(input int c);
    logic [3:0] m;
    m = 4'b0001 << (c % 4);
    return ~m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // sel 0: key_valid, 1: key_pressed, 2: col
  task automatic wait_for(input int sel, input logic [3:0] want, input string name, output int cycles);
    logic [3:0] cur;
    logic hit;
    hit = 1'b0;
    cycles = 999;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      cur = (sel == 0) ? {3'b000, key_valid} : (sel == 1) ? {3'b000, key_pressed} : col;
      if (cur == want) begin
        hit = 1'b1;
        cycles = i;
        break;
      end
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout waiting for %0h at %0t", name, want, $time);
    end
  endtask

  task automatic chk_reset(input string name);
    chk({name, ".col"}, col, 4'b1110);
    chk({name, ".code"}, key_code, 4'h0);
    chk({name, ".valid"}, key_valid, 1'b0);
    chk({name, ".pressed"}, key_pressed, 1'b0);
    chk({name, ".ovf"}, overflow, 1'b0);
  endtask

  task automatic ack_pulse();
    @(negedge clk) key_ack = 1'b1;
    @(negedge clk) key_ack = 1'b0;
  endtask

  task automatic idle_check(input string name, input int n);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seen = seen | key_valid | key_pressed;
    end
    chk(name, seen, 1'b0);
  endtask

  initial begin
    logic [3:0] exp_col;
    reset = 1'b1; key_ack = 1'b0; pressed = 1'b0; glitch = 1'b0; pc = 2'd0; pr = 2'd0;
    tbl[0]  = '{2'd0, 2'd0, 4'h1}; tbl[1]  = '{2'd0, 2'd1, 4'h4};
    tbl[2]  = '{2'd0, 2'd2, 4'h7}; tbl[3]  = '{2'd0, 2'd3, 4'h0};
    tbl[4]  = '{2'd1, 2'd0, 4'h2}; tbl[5]  = '{2'd1, 2'd1, 4'h5};
    tbl[6]  = '{2'd1, 2'd2, 4'h8}; tbl[7]  = '{2'd1, 2'd3, 4'hF};
    tbl[8]  = '{2'd2, 2'd0, 4'h3}; tbl[9]  = '{2'd2, 2'd1, 4'h6};
    tbl[10] = '{2'd2, 2'd2, 4'h9}; tbl[11] = '{2'd2, 2'd3, 4'hE};
    tbl[12] = '{2'd3, 2'd0, 4'hA}; tbl[13] = '{2'd3, 2'd1, 4'hB};
    tbl[14] = '{2'd3, 2'd2, 4'hC}; tbl[15] = '{2'd3, 2'd3, 4'hD};

    repeat (2) @(negedge clk);
    chk_reset("por");
    reset = 1'b0;

    // Idle scan: column rotates every 4 cycles, nothing reported
    exp_col = 4'b1110;
    seen = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n % 4 == 0) exp_col = {exp_col[2:0], exp_col[3]};
      chk("idle.col", col, exp_col);
      seen = seen | key_valid;
    end
    chk("idle.valid", seen, 1'b0);

    // Every key: press, decode, ack, release
    for (int i = 0; i < 16; i++) begin
      pc = tbl[i].c; pr = tbl[i].r; pressed = 1'b1;
      wait_for(0, 4'h1, "key.valid", cyc);
      chk("key.latency_ok", cyc <= 30, 1'b1);
      chk("key.code", key_code, tbl[i].code);
      chk("key.pressed", key_pressed, 1'b1);
      chk("key.col_frozen", col, colmask(tbl[i].c));
      ack_pulse();
      chk("key.acked", key_valid, 1'b0);
      pressed = 1'b0;
      wait_for(1, 4'h0, "key.release", cyc);
      chk("key.col_resume", col, colmask(tbl[i].c + 1));
      chk("key.ovf", overflow, 1'b0);
    end

    // Glitch at the second debounce sample aborts the candidate
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    pc = 2'd0; pr = 2'd2; pressed = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("glitch.frozen", col, 4'b1110);
    @(posedge clk); @(negedge clk) glitch = 1'b1;
    @(posedge clk); @(negedge clk) begin glitch = 1'b0; pressed = 1'b0; end
    @(posedge clk); @(negedge clk);
    chk("glitch.still_frozen", col, 4'b1110);
    @(posedge clk); @(negedge clk);
    chk("glitch.advance", col, 4'b1101);
    chk("glitch.valid", key_valid, 1'b0);
    idle_check("glitch.no_key", 40);

    // Two presses without ack: first code kept, overflow set
    pc = 2'd3; pr = 2'd0; pressed = 1'b1;
    wait_for(0, 4'h1, "ovf.first", cyc);
    chk("ovf.first_code", key_code, 4'hA);
    pressed = 1'b0;
    wait_for(1, 4'h0, "ovf.rel1", cyc);
    pc = 2'd0; pr = 2'd3; pressed = 1'b1;
    wait_for(1, 4'h1, "ovf.second", cyc);
    chk("ovf.code_kept", key_code, 4'hA);
    chk("ovf.valid", key_valid, 1'b1);
    chk("ovf.flag", overflow, 1'b1);
    pressed = 1'b0;
    wait_for(1, 4'h0, "ovf.rel2", cyc);
    ack_pulse();
    chk("ovf.acked", key_valid, 1'b0);
    chk("ovf.sticky", overflow, 1'b1);
    ack_pulse();
    chk("ovf.stray_ack", key_valid, 1'b0);

    // Reset while debouncing a col1 key
    pc = 2'd1; pr = 2'd1; pressed = 1'b1;
    wait_for(2, 4'b1101, "rstdb.col1", cyc);
    repeat (6) @(negedge clk);
    chk("rstdb.frozen", col, 4'b1101);
    chk("rstdb.no_valid", key_valid, 1'b0);
    reset = 1'b1;
    #1;
    chk_reset("rstdb");
    @(negedge clk) pressed = 1'b0;
    @(negedge clk) reset = 1'b0;
    #1 chk("rstdb.restart", col, 4'b1110);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rstdb.next", col, 4'b1101);
    chk("rstdb.discarded", key_valid, 1'b0);

    // Accept coinciding with ack of a pending key
    pc = 2'd0; pr = 2'd0; pressed = 1'b1;
    wait_for(0, 4'h1, "same.pending", cyc);
    chk("same.pending_code", key_code, 4'h1);
    pressed = 1'b0;
    wait_for(1, 4'h0, "same.rel", cyc);
    pc = 2'd2; pr = 2'd3; pressed = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("same.before_code", key_code, 4'h1);
    chk("same.before_pressed", key_pressed, 1'b0);
    key_ack = 1'b1;
    @(posedge clk);
    @(negedge clk) key_ack = 1'b0;
    chk("same.code", key_code, 4'hE);
    chk("same.valid", key_valid, 1'b1);
    chk("same.pressed", key_pressed, 1'b1);
    chk("same.ovf", overflow, 1'b0);
    @(negedge clk);
    chk("same.hold", key_valid, 1'b1);

    // Reset while in release with a pending key and overflow
    pressed = 1'b0;
    wait_for(1, 4'h0, "rstrel.rel", cyc);
    pc = 2'd2; pr = 2'd1; pressed = 1'b1;
    wait_for(1, 4'h1, "rstrel.press", cyc);
    chk("rstrel.ovf", overflow, 1'b1);
    chk("rstrel.col", col, 4'b1011);
    chk("rstrel.code", key_code, 4'hE);
    #2 reset = 1'b1;
    #1;
    chk_reset("rstrel");
    pressed = 1'b0;
    @(negedge clk) reset = 1'b0;
    #1 chk("rstrel.restart", col, 4'b1110);
    idle_check("rstrel.no_key", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
